// File: rtl/sram_like_arbiter.sv
// Arbiter sharing one sram-like master port between IF (inst) and MEM (data).
// Ports: clk, rst (async, high); inst_*/data_* requester ports; m_* master port; busy.
// Optional macro ARB_RR_EN: round-robin between the requesters (default: data > inst).
module sram_like_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inst_req,
  input  logic          inst_wr,
  input  logic [1:0]    inst_size,
  input  logic [AW-1:0] inst_addr,
  input  logic [DW-1:0] inst_wdata,
  output logic          inst_addr_ok,
  output logic          inst_data_ok,
  output logic [DW-1:0] inst_rdata,
  input  logic          data_req,
  input  logic          data_wr,
  input  logic [1:0]    data_size,
  input  logic [AW-1:0] data_addr,
  input  logic [DW-1:0] data_wdata,
  output logic          data_addr_ok,
  output logic          data_data_ok,
  output logic [DW-1:0] data_rdata,
  output logic          m_req,
  output logic          m_wr,
  output logic [1:0]    m_size,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic          m_addr_ok,
  input  logic          m_data_ok,
  input  logic [DW-1:0] m_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_t;

  state_t state;
  state_t state_n;
  // grant/win: 1 = data requester, 0 = inst requester
  logic   grant;
  logic   win;
  logic   any_req;
  logic   take;

  assign any_req = inst_req | data_req;
  assign take    = (state == IDLE) && any_req;

`ifdef ARB_RR_EN
  logic last;

  // On contention the requester not served last time wins.
  always_comb begin
    win = data_req;
    if (inst_req && data_req) begin
      win = ~last;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= 1'b0;
    end else if (take) begin
      last <= win;
    end
  end
`else
  assign win = data_req;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (any_req) state_n = ADDR;
      ADDR: if (m_addr_ok) state_n = DATA;
      DATA: if (m_data_ok) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Winner's request is captured so the master sees it stable in ADDR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant   <= 1'b0;
      m_wr    <= 1'b0;
      m_size  <= 2'b00;
      m_addr  <= '0;
      m_wdata <= '0;
    end else if (take) begin
      grant   <= win;
      m_wr    <= win ? data_wr    : inst_wr;
      m_size  <= win ? data_size  : inst_size;
      m_addr  <= win ? data_addr  : inst_addr;
      m_wdata <= win ? data_wdata : inst_wdata;
    end
  end

  logic in_addr;
  logic in_data;

  assign in_addr = (state == ADDR);
  assign in_data = (state == DATA);

  assign m_req = in_addr;
  assign busy  = (state != IDLE);

  assign inst_addr_ok = in_addr & m_addr_ok & ~grant;
  assign data_addr_ok = in_addr & m_addr_ok &  grant;
  assign inst_data_ok = in_data & m_data_ok & ~grant;
  assign data_data_ok = in_data & m_data_ok &  grant;

  assign inst_rdata = inst_data_ok ? m_rdata : '0;
  assign data_rdata = data_data_ok ? m_rdata : '0;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter; master side driven by hand.
module tb_sram_like_arbiter;

  logic        clk = 0;
  logic        rst = 1;
  logic        inst_req = 0, inst_wr = 0;
  logic [1:0]  inst_size = 0;
  logic [31:0] inst_addr = 0, inst_wdata = 0;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req = 0, data_wr = 0;
  logic [1:0]  data_size = 0;
  logic [31:0] data_addr = 0, data_wdata = 0;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        m_req, m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata;
  logic        m_addr_ok = 0, m_data_ok = 0;
  logic [31:0] m_rdata = 0;
  logic        busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sram_like_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
      $error("%s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic exp_win [4];

  initial begin
    tick();
    tick();
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_m_req", m_req, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_m_wr", m_wr, 0);
    chk("rst_inst_ok", inst_addr_ok | inst_data_ok, 0);
    chk("rst_data_ok", data_addr_ok | data_data_ok, 0);
    rst = 0;

    // T1 lone inst read
    tick();
    inst_req = 1; inst_wr = 0; inst_size = 2;
    inst_addr = 32'h0040_0000;
    @(negedge clk);
    chk("t1_c0_busy", busy, 0);
    chk("t1_c0_m_req", m_req, 0);
    tick();
    m_addr_ok = 1;
    @(negedge clk);
    chk("t1_c1_m_req", m_req, 1);
    chk("t1_c1_m_addr", m_addr, 32'h0040_0000);
    chk("t1_c1_m_size", m_size, 2);
    chk("t1_c1_iaok", inst_addr_ok, 1);
    chk("t1_c1_daok", data_addr_ok, 0);
    tick();
    inst_req = 0; m_addr_ok = 0;
    @(negedge clk);
    chk("t1_c2_m_req", m_req, 0);
    chk("t1_c2_busy", busy, 1);
    chk("t1_c2_idok", inst_data_ok, 0);
    tick();
    m_data_ok = 1; m_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("t1_c3_idok", inst_data_ok, 1);
    chk("t1_c3_irdata", inst_rdata, 32'hDEAD_BEEF);
    chk("t1_c3_ddok", data_data_ok, 0);
    chk("t1_c3_drdata", data_rdata, 0);
    tick();
    m_data_ok = 0;
    @(negedge clk);
    chk("t1_c4_busy", busy, 0);
    chk("t1_c4_irdata", inst_rdata, 0);

    // T2 both request, data wins
    inst_req = 1; inst_addr = 32'h0040_0004;
    data_req = 1; data_wr = 0; data_size = 2;
    data_addr = 32'h0000_1000;
    tick();
    m_addr_ok = 1;
    @(negedge clk);
    chk("t2_m_addr_d", m_addr, 32'h0000_1000);
    chk("t2_daok", data_addr_ok, 1);
    chk("t2_iaok", inst_addr_ok, 0);
    tick();
    data_req = 0; m_addr_ok = 0;
    m_data_ok = 1; m_rdata = 32'hCAFE_0001;
    @(negedge clk);
    chk("t2_ddok", data_data_ok, 1);
    chk("t2_drdata", data_rdata, 32'hCAFE_0001);
    chk("t2_idok", inst_data_ok, 0);
    chk("t2_irdata", inst_rdata, 0);
    tick();
    m_data_ok = 0;
    @(negedge clk);
    chk("t2_gap_m_req", m_req, 0);
    tick();
    m_addr_ok = 1;
    @(negedge clk);
    chk("t2_i_m_req", m_req, 1);
    chk("t2_i_m_addr", m_addr, 32'h0040_0004);
    chk("t2_i_iaok", inst_addr_ok, 1);
    tick();
    inst_req = 0; m_addr_ok = 0;
    m_data_ok = 1; m_rdata = 32'h0000_0011;
    @(negedge clk);
    chk("t2_i_idok", inst_data_ok, 1);
    chk("t2_i_irdata", inst_rdata, 32'h0000_0011);
    tick();
    m_data_ok = 0;

    // T3 data write with delayed m_addr_ok; T6 stray handshakes
    data_req = 1; data_wr = 1; data_size = 2;
    data_addr = 32'h0000_0080; data_wdata = 32'h1234_5678;
    tick();
    for (int i = 0; i < 4; i++) begin
      m_data_ok = (i == 0);
      m_rdata = 32'h0000_0BAD;
      @(negedge clk);
      chk("t3_hold_m_req", m_req, 1);
      chk("t3_hold_m_wr", m_wr, 1);
      chk("t3_hold_wdata", m_wdata, 32'h1234_5678);
      chk("t3_hold_daok", data_addr_ok, 0);
      chk("t6_addr_ddok", data_data_ok, 0);
      chk("t6_addr_drdata", data_rdata, 0);
      tick();
    end
    m_data_ok = 0; m_addr_ok = 1;
    @(negedge clk);
    chk("t3_daok", data_addr_ok, 1);
    chk("t3_m_addr", m_addr, 32'h0000_0080);
    tick();
    data_req = 0; data_wr = 0;
    @(negedge clk);
    chk("t6_data_daok", data_addr_ok, 0);
    chk("t6_data_iaok", inst_addr_ok, 0);
    chk("t6_data_m_req", m_req, 0);
    tick();
    m_addr_ok = 0;
    @(negedge clk);
    chk("t6_still_busy", busy, 1);
    m_data_ok = 1; m_rdata = 0;
    #1;
    chk("t3_ddok", data_data_ok, 1);
    tick();
    m_data_ok = 0;
    @(negedge clk);
    chk("t3_idle", busy, 0);

    // T4 reset while in DATA
    inst_req = 1; inst_addr = 32'h0000_0200;
    tick();
    m_addr_ok = 1;
    tick();
    inst_req = 0; m_addr_ok = 0;
    @(negedge clk);
    chk("t4_pre_busy", busy, 1);
    m_data_ok = 1; m_rdata = 32'h7777_7777;
    rst = 1;
    #1;
    chk("t4_busy", busy, 0);
    chk("t4_m_addr", m_addr, 0);
    chk("t4_m_req", m_req, 0);
    chk("t4_idok", inst_data_ok, 0);
    chk("t4_irdata", inst_rdata, 0);
    tick();
    rst = 0; m_data_ok = 0;
    data_req = 1; data_addr = 32'h0000_0044;
    tick();
    m_addr_ok = 1;
    @(negedge clk);
    chk("t4_new_m_addr", m_addr, 32'h0000_0044);
    chk("t4_new_daok", data_addr_ok, 1);
    tick();
    data_req = 0; m_addr_ok = 0;
    m_data_ok = 1; m_rdata = 32'h5555_5555;
    @(negedge clk);
    chk("t4_new_drdata", data_rdata, 32'h5555_5555);
    tick();
    m_data_ok = 0;

    // T5 both requesters always requesting, 4 transactions
    rst = 1;
    tick();
    rst = 0;
`ifdef ARB_RR_EN
    exp_win = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_win = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    inst_req = 1; inst_addr = 32'h0000_0A00;
    data_req = 1; data_addr = 32'h0000_0D00;
    for (int k = 0; k < 4; k++) begin
      tick();
      m_addr_ok = 1;
      @(negedge clk);
      chk("t5_m_addr", m_addr,
          exp_win[k] ? 32'h0000_0D00 : 32'h0000_0A00);
      chk("t5_daok", data_addr_ok, exp_win[k]);
      chk("t5_iaok", inst_addr_ok, !exp_win[k]);
      tick();
      m_addr_ok = 0; m_data_ok = 1;
      tick();
      m_data_ok = 0;
    end
    inst_req = 0; data_req = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
